// File: rtl/gray_counter.sv
// gray_counter: up/down binary counter with registered Gray-code output, preset load,
// optional saturation at the ends, and wrap/limit/step status flags.
module gray_counter #(
  parameter int WIDTH    = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] gray_out,
  output logic [WIDTH-1:0] bin_cnt,
  output logic             wrap,
  output logic             at_limit,
  output logic             step
);
  logic             hold;
  logic [WIDTH-1:0] nxt;
  always_comb begin
    at_limit = up_dn ? &bin_cnt : ~|bin_cnt;
    hold     = at_limit && SATURATE;
    nxt      = load ? load_bin :
               (!en || hold) ? bin_cnt :
               up_dn ? bin_cnt + 1'b1 : bin_cnt - 1'b1;
  end
  // Gray is a bijection of binary, so a Gray change is exactly a binary change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_cnt  <= '0;
      gray_out <= '0;
      wrap     <= 1'b0;
      step     <= 1'b0;
    end else begin
      bin_cnt  <= nxt;
      gray_out <= nxt ^ (nxt >> 1);
      wrap     <= !load && en && at_limit && !SATURATE;
      step     <= nxt != bin_cnt;
    end
  end
endmodule
